uart_rx_framer: RTL
===================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning maximum payload bytes per frame (2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000, meaning inter-byte timeout in clk cycles (16-bit counter minimum).
REQ-003 SHALL have port clk input 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port nrst input 1, reset that is synchronous and active-low.
REQ-005 SHALL have ports rx_data input 8, rx_done input 1 and rx_err input 1, the byte and its single-cycle strobes from the UART receiver.
REQ-006 SHALL have ports out_data output 8, out_valid output 1, out_ready input 1 and out_last output 1, the validated payload stream.
REQ-007 SHALL have port busy output 1, high whenever the state is not IDLE.
REQ-008 SHALL have ports err_len, err_chk, err_rx, err_tmo and err_ovr, each output 1, single-cycle error pulses.

Function
REQ-009 SHALL accept frames of the form SYNC (0xA5), LEN, LEN payload bytes, CHK, where CHK = XOR of LEN and all payload bytes.
REQ-010 SHALL implement the states IDLE, LEN, PAYLOAD, CHK and DRAIN.
REQ-011 SHALL behave in IDLE as follows: rx_done with 0xA5 -> LEN; any other byte is discarded silently; rx_err is ignored.
REQ-012 SHALL behave in LEN as follows: LEN in 1..MAX_LEN -> store LEN, seed checksum with LEN, clear write index, go to PAYLOAD; LEN 0 or > MAX_LEN -> pulse err_len, go to IDLE.
REQ-013 SHALL behave in PAYLOAD as follows: each rx_done writes buf[idx], XORs the byte into the checksum and increments idx; the byte with idx == LEN-1 -> CHK.
REQ-014 SHALL behave in CHK as follows: byte == checksum -> DRAIN with read index 0; mismatch -> pulse err_chk, go to IDLE, emit no output.
REQ-015 SHALL assert out_valid the cycle after the CHK byte's rx_done, with out_data = buf[rd_idx] and out_last = (rd_idx == LEN-1).
REQ-016 SHALL follow the handshake rule that a transfer occurs when out_valid && out_ready; out_data and out_last hold while out_valid && !out_ready; out_valid never drops before the transfer.
REQ-017 SHALL return to IDLE after the out_last transfer, with out_valid low in the following cycle.
REQ-018 SHALL drop any rx_done arriving in DRAIN and pulse err_ovr in the same cycle; the in-progress output is unaffected.
REQ-019 SHALL, on rx_err in LEN, PAYLOAD or CHK, pulse err_rx, go to IDLE and discard the partial frame.
REQ-020 SHALL give rx_err priority over rx_done if both are asserted in the same cycle.
REQ-021 SHALL pulse each error output for exactly one cycle, with no more than one error pulse per cycle.
REQ-022 SHALL use an index width of $clog2(MAX_LEN) and SHALL never let the index wrap past LEN-1.

Reset
REQ-023 SHALL, while nrst is low at a clk edge, enter IDLE and clear out_valid, out_last, out_data, busy, all err_* outputs, the indexes, the checksum and the timeout counter to 0.
REQ-024 SHALL abandon any frame or drain in progress on reset mid-operation, with no output transfer after reset.
REQ-025 SHALL leave buffer contents unreset and SHALL never output them unvalidated.

Configuration
REQ-026 SHALL, with UART_RX_FRAMER_TIMEOUT_EN defined, count cycles since the last rx_done in LEN, PAYLOAD and CHK; reaching TIMEOUT_CYCLES -> pulse err_tmo, go to IDLE.
REQ-027 SHALL reload the timeout counter on every rx_done, and SHALL give rx_done in the expiry cycle priority over the timeout.
REQ-028 SHALL NOT count the timeout in IDLE or DRAIN.
REQ-029 SHALL, without UART_RX_FRAMER_TIMEOUT_EN, have no timeout logic and tie err_tmo to 0; TIMEOUT_CYCLES is then unused.

Structure
REQ-030 SHALL place SYNC_BYTE (8'hA5) and the state enum type in shared package uart_pkg.
REQ-031 SHALL implement payload storage as sub-module uart_frame_buf, a MAX_LEN x 8 array with one write port and a combinational read port.
REQ-032 SHALL keep the FSM, checksum, indexes and timeout counter in uart_rx_framer.

Verification
REQ-033 SHALL cover the good frame: A5 03 11 22 33 CHK=03^11^22^33=0x03 with out_ready=1 -> out_data 11,22,33 on consecutive cycles, out_last on 33, then IDLE.
REQ-034 SHALL cover backpressure: same frame with out_ready low for 5 cycles -> out_valid held, out_data stable at 0x11, then 3 transfers.
REQ-035 SHALL cover bad length and checksum: A5 00 -> err_len pulse; A5 11 (MAX_LEN=16) -> err_len; A5 01 55 00 -> err_chk, out_valid never high.
REQ-036 SHALL cover rx_err mid-frame: A5 02 AA then rx_err -> err_rx pulse, IDLE; a following good frame A5 01 7E 7F -> outputs 7E with out_last.
REQ-037 SHALL cover timeout: with the macro defined and TIMEOUT_CYCLES=50, send A5 02 then idle for 50 cycles -> err_tmo exactly once; without the macro, the FSM stays in PAYLOAD.
REQ-038 SHALL cover overrun and reset: rx_done during DRAIN with out_ready=0 -> err_ovr pulse, output unchanged; nrst low in PAYLOAD -> all outputs 0, IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared SYNC byte and framer state encoding.
// Revision : 1.0 - initial release
// ============================================================================

package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_buf
// Brief    : MAX_LEN x 8 payload store, one write port, combinational read.
// Revision : 1.0 - initial release
// ============================================================================

module uart_frame_buf #(
    parameter int MAX_LEN = 16
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
    output logic [7:0]                 rd_data
);

    // Contents are deliberately not reset; the framer only exposes them once validated.
    logic [7:0] r_mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_framer
// Brief    : Validates SYNC/LEN/payload/CHK frames and streams the payload
//            out on a valid/ready port. Inter-byte timeout is built only
//            when UART_RX_FRAMER_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_err,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_rx,
    output logic       err_tmo,
    output logic       err_ovr
);

    localparam int IW = $clog2(MAX_LEN);

    if (MAX_LEN < 2 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("uart_rx_framer: parameter out of range");
    end

    state_t        r_state, w_next_state;
    logic [7:0]    r_len, w_next_len;
    logic [7:0]    r_chk, w_next_chk;
    logic [IW-1:0] r_wr_idx, w_next_wr_idx;
    logic [IW-1:0] r_rd_idx, w_next_rd_idx;
    logic          w_buf_we;
    logic [7:0]    w_buf_rd;
    logic          w_wr_last, w_rd_last, w_active, w_tmo_hit;
    logic          w_err_len, w_err_chk, w_err_rx, w_err_tmo, w_err_ovr;

    assign w_wr_last = (8'(r_wr_idx) == r_len - 8'd1);
    assign w_rd_last = (8'(r_rd_idx) == r_len - 8'd1);
    assign w_active  = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);

`ifdef UART_RX_FRAMER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;

    logic [TW-1:0] r_tmo;

    // A byte arriving in the expiry cycle wins; the count restarts from it.
    assign w_tmo_hit = w_active && !rx_done && !rx_err &&
                       (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_tmo <= '0;
        end else if (!w_active || rx_done || w_tmo_hit) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_chk    <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
        end else begin
            r_state  <= w_next_state;
            r_len    <= w_next_len;
            r_chk    <= w_next_chk;
            r_wr_idx <= w_next_wr_idx;
            r_rd_idx <= w_next_rd_idx;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_len    = r_len;
        w_next_chk    = r_chk;
        w_next_wr_idx = r_wr_idx;
        w_next_rd_idx = r_rd_idx;
        w_buf_we      = 1'b0;
        w_err_len     = 1'b0;
        w_err_chk     = 1'b0;
        w_err_rx      = 1'b0;
        w_err_tmo     = 1'b0;
        w_err_ovr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_done && !rx_err && rx_data == SYNC_BYTE) begin
                    w_next_state = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_err) begin
                    w_err_rx     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (rx_done) begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        w_err_len    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_len    = rx_data;
                        w_next_chk    = rx_data;
                        w_next_wr_idx = '0;
                        w_next_state  = ST_PAYLOAD;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_err) begin
                    w_err_rx     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (rx_done) begin
                    w_buf_we   = 1'b1;
                    w_next_chk = r_chk ^ rx_data;
                    // Index parks on LEN-1 instead of wrapping.
                    if (w_wr_last) begin
                        w_next_state = ST_CHK;
                    end else begin
                        w_next_wr_idx = r_wr_idx + IW'(1);
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (rx_err) begin
                    w_err_rx     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (rx_done) begin
                    if (rx_data == r_chk) begin
                        w_next_rd_idx = '0;
                        w_next_state  = ST_DRAIN;
                    end else begin
                        w_err_chk    = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_err_ovr = rx_done && !rx_err;
                if (out_ready) begin
                    if (w_rd_last) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_rd_idx = r_rd_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_buf_we),
        .wr_addr (r_wr_idx),
        .wr_data (rx_data),
        .rd_addr (r_rd_idx),
        .rd_data (w_buf_rd)
    );

    // Outputs are forced low while nrst is held so nothing transfers during reset.
    assign busy      = nrst && (r_state != ST_IDLE);
    assign out_valid = nrst && (r_state == ST_DRAIN);
    assign out_last  = out_valid && w_rd_last;
    assign out_data  = out_valid ? w_buf_rd : 8'h00;
    assign err_len   = nrst && w_err_len;
    assign err_chk   = nrst && w_err_chk;
    assign err_rx    = nrst && w_err_rx;
    assign err_tmo   = nrst && w_err_tmo;
    assign err_ovr   = nrst && w_err_ovr;

endmodule

`default_nettype wire
